// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory arbiter: FSM state encoding,
// requester (owner) encoding and the wait-state counter width.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      ACCESS = 2'b01,
      DONE   = 2'b10
   } state_t;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_DM = 1'b1
   } owner_t;

   localparam int CNT_W = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant chooser for the memory arbiter.
// Optional build macro: MEM_ARB_RR_EN selects round-robin tie breaking
// (the requester not granted last wins); without it DM always beats IF.
module mem_arb_pick
   import mem_arb_pkg::*;
(
   input  logic   if_req,
   input  logic   dm_req,
   input  owner_t last_owner,
   output owner_t grant_owner
);

   // Choose who gets the RAM next; with no request the choice is unused,
   // so it simply keeps pointing at the previous owner.
   always_comb begin
      grant_owner = last_owner;
`ifdef MEM_ARB_RR_EN
      if (if_req && dm_req) begin
         grant_owner = (last_owner == OWN_IF) ? OWN_DM : OWN_IF;
      end else if (dm_req) begin
         grant_owner = OWN_DM;
      end else if (if_req) begin
         grant_owner = OWN_IF;
      end
`else
      if (dm_req) begin
         grant_owner = OWN_DM;
      end else if (if_req) begin
         grant_owner = OWN_IF;
      end
`endif
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port RAM between instruction fetch (IF) and
// data load/store (DM). Each access holds ram_enabler for RAM_LAT cycles and
// ends with a one-cycle ready pulse to the owner. All outputs are registered.
// Optional build macro: MEM_ARB_RR_EN enables round-robin tie breaking.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int RAM_LAT = 1
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic [DW-1:0] if_rdata,
   output logic          if_ready,
   input  logic          dm_req,
   input  logic          dm_we,
   input  logic [AW-1:0] dm_addr,
   input  logic [DW-1:0] dm_wdata,
   output logic [DW-1:0] dm_rdata,
   output logic          dm_ready,
   output logic          ram_enabler,
   output logic          ram_we,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_wdata,
   input  logic [DW-1:0] ram_rdata
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RAM_LAT - 1);

   state_t            r_state;
   state_t            w_nextState;
   logic              w_startAccess;
   logic              w_lastBeat;
   logic [CNT_W-1:0]  r_count;
   owner_t            r_owner;
   owner_t            w_grantOwner;
   owner_t            w_lastOwner;
   logic              r_ramEn;
   logic              r_ramWe;
   logic [AW-1:0]     r_ramAddr;
   logic [DW-1:0]     r_ramWdata;
   logic [DW-1:0]     r_ifRdata;
   logic [DW-1:0]     r_dmRdata;
   logic              r_ifReady;
   logic              r_dmReady;

`ifdef MEM_ARB_RR_EN
   owner_t            r_lastOwner;

   // Remember who was granted most recently so the next tie goes the other way;
   // starting at DM lets IF win the very first tie.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_lastOwner <= OWN_DM;
      end else if (w_startAccess) begin
         r_lastOwner <= w_grantOwner;
      end
   end

   assign w_lastOwner = r_lastOwner;
`else
   assign w_lastOwner = OWN_DM;
`endif

   mem_arb_pick u_pick (
      .if_req      (if_req),
      .dm_req      (dm_req),
      .last_owner  (w_lastOwner),
      .grant_owner (w_grantOwner)
   );

   // State register; reset aborts any access in flight straight back to IDLE.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic: start on any sampled request, finish after the last
   // wait-state beat, and spend exactly one cycle in DONE for the ready pulse.
   always_comb begin
      w_nextState   = r_state;
      w_startAccess = 1'b0;
      w_lastBeat    = 1'b0;
      case (r_state)
         IDLE: begin
            if (if_req || dm_req) begin
               w_nextState   = ACCESS;
               w_startAccess = 1'b1;
            end
         end
         ACCESS: begin
            if (r_count == LAST_CNT) begin
               w_nextState = DONE;
               w_lastBeat  = 1'b1;
            end
         end
         DONE: begin
            w_nextState = IDLE;
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // Datapath: latch the granted request at start, drive the RAM strobes for
   // the access, then capture read data and raise the owner's ready pulse.
   // Stores leave dm_rdata untouched; the strobes return to 0 once done.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_count    <= '0;
         r_owner    <= OWN_IF;
         r_ramEn    <= 1'b0;
         r_ramWe    <= 1'b0;
         r_ramAddr  <= '0;
         r_ramWdata <= '0;
         r_ifRdata  <= '0;
         r_dmRdata  <= '0;
         r_ifReady  <= 1'b0;
         r_dmReady  <= 1'b0;
      end else begin
         r_ifReady <= 1'b0;
         r_dmReady <= 1'b0;
         if (w_startAccess) begin
            r_owner <= w_grantOwner;
            r_count <= '0;
            r_ramEn <= 1'b1;
            if (w_grantOwner == OWN_DM) begin
               r_ramWe    <= dm_we;
               r_ramAddr  <= dm_addr;
               r_ramWdata <= dm_wdata;
            end else begin
               r_ramWe    <= 1'b0;
               r_ramAddr  <= if_addr;
               r_ramWdata <= '0;
            end
         end else if (w_lastBeat) begin
            r_ramEn    <= 1'b0;
            r_ramWe    <= 1'b0;
            r_ramAddr  <= '0;
            r_ramWdata <= '0;
            if (r_owner == OWN_IF) begin
               r_ifRdata <= ram_rdata;
               r_ifReady <= 1'b1;
            end else begin
               if (!r_ramWe) begin
                  r_dmRdata <= ram_rdata;
               end
               r_dmReady <= 1'b1;
            end
         end else if (r_state == ACCESS) begin
            r_count <= r_count + CNT_W'(1);
         end
      end
   end

   assign ram_enabler = r_ramEn;
   assign ram_we      = r_ramWe;
   assign ram_addr    = r_ramAddr;
   assign ram_wdata   = r_ramWdata;
   assign if_rdata    = r_ifRdata;
   assign if_ready    = r_ifReady;
   assign dm_rdata    = r_dmRdata;
   assign dm_ready    = r_dmReady;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter. Instance A runs with RAM_LAT=1 and
// instance B with RAM_LAT=3; both share clock and reset.
module tb_mem_arbiter;

   logic clk;
   logic rst;

   logic        a_ifReq, a_dmReq, a_dmWe;
   logic [31:0] a_ifAddr, a_dmAddr, a_dmWdata, a_ramRdata;
   logic [31:0] a_ifRdata, a_dmRdata, a_ramAddr, a_ramWdata;
   logic        a_ifReady, a_dmReady, a_ramEn, a_ramWe;

   logic        b_ifReq, b_dmReq, b_dmWe;
   logic [31:0] b_ifAddr, b_dmAddr, b_dmWdata, b_ramRdata;
   logic [31:0] b_ifRdata, b_dmRdata, b_ramAddr, b_ramWdata;
   logic        b_ifReady, b_dmReady, b_ramEn, b_ramWe;

   int nAsserts = 0;
   int nFails   = 0;

   logic        firstIsDm;
   logic        expDm;
   logic [31:0] expRdata;

   mem_arbiter #(.AW(32), .DW(32), .RAM_LAT(1)) dutA (
      .clk(clk), .rst(rst),
      .if_req(a_ifReq), .if_addr(a_ifAddr), .if_rdata(a_ifRdata), .if_ready(a_ifReady),
      .dm_req(a_dmReq), .dm_we(a_dmWe), .dm_addr(a_dmAddr), .dm_wdata(a_dmWdata),
      .dm_rdata(a_dmRdata), .dm_ready(a_dmReady),
      .ram_enabler(a_ramEn), .ram_we(a_ramWe), .ram_addr(a_ramAddr),
      .ram_wdata(a_ramWdata), .ram_rdata(a_ramRdata)
   );

   mem_arbiter #(.AW(32), .DW(32), .RAM_LAT(3)) dutB (
      .clk(clk), .rst(rst),
      .if_req(b_ifReq), .if_addr(b_ifAddr), .if_rdata(b_ifRdata), .if_ready(b_ifReady),
      .dm_req(b_dmReq), .dm_we(b_dmWe), .dm_addr(b_dmAddr), .dm_wdata(b_dmWdata),
      .dm_rdata(b_dmRdata), .dm_ready(b_dmReady),
      .ram_enabler(b_ramEn), .ram_we(b_ramWe), .ram_addr(b_ramAddr),
      .ram_wdata(b_ramWdata), .ram_rdata(b_ramRdata)
   );

   // Free-running 10 ns clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance to 1 ns after the next rising edge, where outputs are stable and
   // inputs can be changed safely for the following edge.
   task automatic applyStimulus();
      @(posedge clk);
      #1;
   endtask

   // One comparison: count it, and report tag/observed/expected on mismatch.
   task automatic checkOutput(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      nAsserts++;
      assert (obs === exp) else begin
         nFails++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Directed test sequence.
   initial begin
      rst = 1'b0;
      a_ifReq = 0; a_dmReq = 0; a_dmWe = 0;
      a_ifAddr = 0; a_dmAddr = 0; a_dmWdata = 0; a_ramRdata = 0;
      b_ifReq = 0; b_dmReq = 0; b_dmWe = 0;
      b_ifAddr = 0; b_dmAddr = 0; b_dmWdata = 0; b_ramRdata = 0;
`ifdef MEM_ARB_RR_EN
      firstIsDm = 1'b0;
`else
      firstIsDm = 1'b1;
`endif

      $display("[TB] reset held with requests toggling");
      for (int i = 0; i < 19; i++) begin
         #10;
         a_ifReq = ~a_ifReq; a_dmReq = ~a_dmReq;
         b_ifReq = ~b_ifReq; b_dmReq = ~b_dmReq; b_dmWe = ~b_dmWe;
         a_ifAddr = 32'h100 + i; b_dmAddr = 32'h200 + i;
         #1;
         checkOutput("rst_zero_A", {28'd0, a_ifRdata, a_ifReady, a_dmRdata, a_dmReady,
                                    a_ramEn, a_ramWe, a_ramAddr, a_ramWdata}, '0);
         checkOutput("rst_zero_B", {28'd0, b_ifRdata, b_ifReady, b_dmRdata, b_dmReady,
                                    b_ramEn, b_ramWe, b_ramAddr, b_ramWdata}, '0);
      end
      a_ifReq = 0; a_dmReq = 0; b_ifReq = 0; b_dmReq = 0; b_dmWe = 0;
      #5;
      rst = 1'b1;
      applyStimulus();
      applyStimulus();
      checkOutput("idle_no_en_A", {159'd0, a_ramEn}, '0);
      checkOutput("idle_no_en_B", {159'd0, b_ramEn}, '0);

      $display("[TB] single fetch, RAM_LAT=1");
      a_ifReq = 1; a_ifAddr = 32'h0000_0004; a_ramRdata = 32'h2008_0005;
      applyStimulus();
      checkOutput("fetch_en", {159'd0, a_ramEn}, 160'd1);
      checkOutput("fetch_addr", {128'd0, a_ramAddr}, 160'h4);
      checkOutput("fetch_we", {159'd0, a_ramWe}, '0);
      checkOutput("fetch_notready", {159'd0, a_ifReady}, '0);
      applyStimulus();
      checkOutput("fetch_ready", {158'd0, a_ifReady, a_ramEn}, 160'b10);
      checkOutput("fetch_rdata", {128'd0, a_ifRdata}, 160'h2008_0005);
      a_ifReq = 0; a_ramRdata = 32'h0BAD_0BAD;
      applyStimulus();
      checkOutput("fetch_ready_1cyc", {158'd0, a_ifReady, a_ramEn}, '0);
      checkOutput("fetch_rdata_hold", {128'd0, a_ifRdata}, 160'h2008_0005);

      $display("[TB] store, RAM_LAT=3");
      b_dmReq = 1; b_dmWe = 1; b_dmAddr = 32'h10; b_dmWdata = 32'hDEAD_BEEF;
      b_ramRdata = 32'h1234_5678;
      for (int i = 0; i < 3; i++) begin
         applyStimulus();
         checkOutput("store_strobes", {125'd0, b_ramEn, b_ramWe, b_dmReady, b_ramAddr, b_ramWdata},
                     {125'd0, 3'b110, 32'h10, 32'hDEAD_BEEF});
         b_dmWdata = 32'h0; b_dmAddr = 32'hFFFF_FFF0;
      end
      applyStimulus();
      checkOutput("store_done", {157'd0, b_ramEn, b_ramWe, b_dmReady}, 160'b001);
      checkOutput("store_rdata_kept", {128'd0, b_dmRdata}, '0);
      b_dmReq = 0; b_dmWe = 0;
      applyStimulus();
      checkOutput("store_ready_1cyc", {159'd0, b_dmReady}, '0);

      $display("[TB] simultaneous requests, RAM_LAT=1");
      a_ifReq = 1; a_ifAddr = 32'h100; a_dmReq = 1; a_dmWe = 0; a_dmAddr = 32'h200;
      a_ramRdata = 32'hAAAA_0001;
      applyStimulus();
      checkOutput("tie_first_addr", {128'd0, a_ramAddr}, {128'd0, firstIsDm ? 32'h200 : 32'h100});
      applyStimulus();
      checkOutput("tie_first_ready", {158'd0, a_ifReady, a_dmReady},
                  {158'd0, firstIsDm ? 2'b01 : 2'b10});
      checkOutput("tie_first_rdata", {128'd0, firstIsDm ? a_dmRdata : a_ifRdata}, 160'hAAAA_0001);
      if (firstIsDm) a_dmReq = 0; else a_ifReq = 0;
      a_ramRdata = 32'hBBBB_0002;
      applyStimulus();
      checkOutput("tie_gap", {158'd0, a_ifReady, a_dmReady}, '0);
      applyStimulus();
      checkOutput("tie_second_addr", {128'd0, a_ramAddr}, {128'd0, firstIsDm ? 32'h100 : 32'h200});
      applyStimulus();
      checkOutput("tie_second_ready", {158'd0, a_ifReady, a_dmReady},
                  {158'd0, firstIsDm ? 2'b10 : 2'b01});
      checkOutput("tie_second_rdata", {128'd0, firstIsDm ? a_ifRdata : a_dmRdata}, 160'hBBBB_0002);
      a_ifReq = 0; a_dmReq = 0;
      applyStimulus();

      $display("[TB] both requests held for four accesses");
      a_ifReq = 1; a_dmReq = 1;
      for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_RR_EN
         expDm = (i % 2) == 1;
`else
         expDm = 1'b1;
`endif
         expRdata = 32'hC000_0000 + i;
         a_ramRdata = expRdata;
         applyStimulus();
         checkOutput("held_addr", {128'd0, a_ramAddr}, {128'd0, expDm ? 32'h200 : 32'h100});
         applyStimulus();
         checkOutput("held_ready", {158'd0, a_ifReady, a_dmReady}, {158'd0, expDm ? 2'b01 : 2'b10});
         checkOutput("held_rdata", {128'd0, expDm ? a_dmRdata : a_ifRdata}, {128'd0, expRdata});
         if (i == 3) begin
            a_ifReq = 0; a_dmReq = 0;
         end
         applyStimulus();
      end

      $display("[TB] reset during access, RAM_LAT=3");
      b_ifReq = 1; b_ifAddr = 32'h40; b_ramRdata = 32'h0000_0055;
      applyStimulus();
      checkOutput("abort_en_before", {159'd0, b_ramEn}, 160'd1);
      applyStimulus();
      #2;
      rst = 1'b0;
      #1;
      checkOutput("abort_async_clear", {157'd0, b_ramEn, b_ifReady, b_dmReady}, '0);
      checkOutput("abort_addr_clear", {128'd0, b_ramAddr}, '0);
      #3;
      rst = 1'b1;
      applyStimulus();
      checkOutput("restart_cyc1", {158'd0, b_ramEn, b_ifReady}, 160'b10);
      checkOutput("restart_addr", {128'd0, b_ramAddr}, 160'h40);
      applyStimulus();
      checkOutput("restart_cyc2", {158'd0, b_ramEn, b_ifReady}, 160'b10);
      applyStimulus();
      checkOutput("restart_cyc3", {158'd0, b_ramEn, b_ifReady}, 160'b10);
      b_ifReq = 0;
      applyStimulus();
      checkOutput("restart_ready", {158'd0, b_ramEn, b_ifReady}, 160'b01);
      checkOutput("restart_rdata", {128'd0, b_ifRdata}, 160'h55);
      applyStimulus();
      checkOutput("restart_ready_1cyc", {159'd0, b_ifReady}, '0);

      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
      $finish;
   end

endmodule
